// File: rtl/relu_fwd_mask.sv
// relu_fwd_mask: forward ReLU on 18-bit FloPoCo words, with an in-order mask FIFO
// that records which elements were clamped. The backward pass consumes the mask stream.
module relu_fwd_mask #(
  parameter int BITWIDTH   = 16,
  parameter int BW         = BITWIDTH + 2 - 1,
  parameter int MASK_DEPTH = 64,
  parameter int AW         = $clog2(MASK_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW:0]   out_data,
  output logic          mask_valid,
  input  logic          mask_ready,
  output logic          mask_out,
  output logic [AW:0]   mask_count
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(MASK_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(MASK_DEPTH - 1);

  logic                  r_out_valid;
  logic [BW:0]           r_out_data;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [MASK_DEPTH-1:0] r_mask;

  logic                  w_in_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_mask_valid;
  logic [BW:0]           w_relu_data;
  logic                  w_relu_mask;
  logic [1:0]            w_exn;
  logic                  w_sign;

  // Pointer advance with explicit wrap so non-power-of-2 depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_exn        = in_data[BW:BW-1];
  assign w_sign       = in_data[BW-2];
  assign w_mask_valid = (r_count != '0);

  // Accept only when the FIFO has room (registered count) and the output slot frees up.
  assign w_in_ready = enable && !clear && (r_count != FULL_CNT) && (!r_out_valid || out_ready);
  assign w_push     = in_valid && w_in_ready;
  assign w_pop      = enable && !clear && w_mask_valid && mask_ready;

  // ReLU rule: NaN passes unchanged, zero/negative clamp to 0, positive passes.
  always_comb begin
    w_relu_data = in_data;
    w_relu_mask = 1'b0;
    if (w_exn == 2'b11) begin
      w_relu_mask = 1'b1;
    end else if ((w_exn == 2'b00) || w_sign) begin
      w_relu_data = '0;
      w_relu_mask = 1'b1;
    end
  end

  // Output register: load on push, drop valid on drain, clear flushes valid only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
    end else if (w_push) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_relu_data;
    end else if (enable && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Mask FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Mask storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mask[r_wr_ptr] <= w_relu_mask;
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign mask_valid = w_mask_valid;
  assign mask_out   = r_mask[r_rd_ptr];
  assign mask_count = r_count;

endmodule

// File: tb/tb_relu_fwd_mask.sv
// Scoreboard bench for relu_fwd_mask: stimulus pushes expected results/masks on
// accepted inputs; a negedge monitor pops and compares on every output/mask handshake.
module tb_relu_fwd_mask;

  localparam int BW    = 17;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          mask_ready = 1'b0;
  logic [BW:0]   in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [BW:0]   out_data;
  logic          mask_valid;
  logic          mask_out;
  logic [AW:0]   mask_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW:0] out_q[$];
  logic        mask_q[$];

  relu_fwd_mask #(.BITWIDTH(16), .MASK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .mask_out(mask_out),
    .mask_count(mask_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare on handshakes that will complete at the next rising edge.
  always @(negedge clk) begin : monitor
    logic [BW:0] e;
    logic        m;
    if (rst_n && enable && !clear) begin
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          chk("out_unexpected", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = out_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
        end
      end
      if (mask_valid && mask_ready) begin
        if (mask_q.size() == 0) begin
          chk("mask_unexpected", 32'(mask_out), 32'hFFFF_FFFF);
        end else begin
          m = mask_q.pop_front();
          chk("mask_out", 32'(mask_out), 32'(m));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; record expectation when accepted. Leaves in_valid high.
  task automatic send(input logic [BW:0] d, input logic [BW:0] eo, input logic em, output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (in_ready) begin
        out_q.push_back(eo);
        mask_q.push_back(em);
        ok = 1'b1;
      end
      tick();
    end
    chk("send_accept", 32'(ok), 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    mask_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!out_valid && !mask_valid) done = 1'b1;
      tick();
    end
    chk("drain_done", 32'(done), 1);
    chk("out_q_empty", 32'(out_q.size()), 0);
    chk("mask_q_empty", 32'(mask_q.size()), 0);
    mask_ready = 1'b0;
  endtask

  initial begin
    int c;
    logic [BW:0] d;

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_mask_count", 32'(mask_count), 0);
    chk("rst_mask_valid", 32'(mask_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    tick(); tick();
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 1);
    tick();

    // 1: +1.0 passes with one cycle latency, mask 0
    out_ready = 1'b1;
    send(18'h13C00, 18'h13C00, 1'b0, c);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_out_data", 32'(out_data), 'h13C00);
    chk("t1_mask_out", 32'(mask_out), 0);
    chk("t1_mask_count", 32'(mask_count), 1);
    tick();
    drain();

    // 2: -2.0, zero, NaN
    mask_ready = 1'b0;
    out_ready  = 1'b1;
    send(18'h1C000, 18'h00000, 1'b1, c);
    send(18'h00000, 18'h00000, 1'b1, c);
    send(18'h3FFFF, 18'h3FFFF, 1'b1, c);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_mask_count", 32'(mask_count), 3);
    tick();
    drain();

    // 3: fill to 64, pop one, 65th accepted after pointer wrap
    mask_ready = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 2 == 1) begin
        d = 18'h1C000 | 18'(i);
        send(d, 18'h00000, 1'b1, c);
      end else begin
        d = 18'h13C00 | 18'(i);
        send(d, d, 1'b0, c);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_full_count", 32'(mask_count), 64);
    chk("t3_full_in_ready", 32'(in_ready), 0);
    tick();
    mask_ready = 1'b1;
    @(negedge clk);
    chk("t3_pop_cycle_in_ready", 32'(in_ready), 0);
    tick();
    mask_ready = 1'b0;
    @(negedge clk);
    chk("t3_after_pop_count", 32'(mask_count), 63);
    chk("t3_after_pop_in_ready", 32'(in_ready), 1);
    tick();
    send(18'h17C00, 18'h17C00, 1'b0, c);
    chk("t3_65th_latency", 32'(c), 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_refull_count", 32'(mask_count), 64);
    tick();
    drain();

    // 4: output stall holds data and blocks input; then back-to-back transfers
    out_ready = 1'b0;
    send(18'h14200, 18'h14200, 1'b0, c);
    in_data = 18'h14400;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stall_valid", 32'(out_valid), 1);
      chk("t4_stall_data", 32'(out_data), 'h14200);
      chk("t4_stall_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    send(18'h14400, 18'h14400, 1'b0, c);
    chk("t4_b2b_0", 32'(c), 1);
    send(18'h1C400, 18'h00000, 1'b1, c);
    chk("t4_b2b_1", 32'(c), 1);
    send(18'h14800, 18'h14800, 1'b0, c);
    chk("t4_b2b_2", 32'(c), 1);
    send(18'h3FC01, 18'h3FC01, 1'b1, c);
    chk("t4_b2b_3", 32'(c), 1);
    drain();

    // 5: clear with simultaneous push and pop attempt
    mask_ready = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 18'h14000 | 18'(i);
      send(d, d, 1'b0, c);
    end
    clear      = 1'b1;
    in_valid   = 1'b1;
    in_data    = 18'h15000;
    mask_ready = 1'b1;
    @(negedge clk);
    chk("t5_pre_count", 32'(mask_count), 10);
    chk("t5_clear_in_ready", 32'(in_ready), 0);
    tick();
    clear      = 1'b0;
    in_valid   = 1'b0;
    mask_ready = 1'b0;
    out_q.delete();
    mask_q.delete();
    @(negedge clk);
    chk("t5_count", 32'(mask_count), 0);
    chk("t5_out_valid", 32'(out_valid), 0);
    chk("t5_mask_valid", 32'(mask_valid), 0);
    chk("t5_out_data_held", 32'(out_data), 'h14009);
    tick();

    // 6a: async reset mid-burst
    out_ready  = 1'b1;
    mask_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 18'h14800 | 18'(i);
      send(d, d, 1'b0, c);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_count", 32'(mask_count), 0);
    chk("t6_rst_mask_valid", 32'(mask_valid), 0);
    chk("t6_rst_out_data", 32'(out_data), 0);
    out_q.delete();
    mask_q.delete();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 6b: enable low freezes everything
    out_ready = 1'b0;
    send(18'h15400, 18'h15400, 1'b0, c);
    enable     = 1'b0;
    in_valid   = 1'b1;
    in_data    = 18'h15800;
    out_ready  = 1'b1;
    mask_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_en_in_ready", 32'(in_ready), 0);
      chk("t6_en_out_valid", 32'(out_valid), 1);
      chk("t6_en_out_data", 32'(out_data), 'h15400);
      chk("t6_en_count", 32'(mask_count), 1);
      tick();
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
